spi_slave_core: RTL and testbench
=================================

SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

Interface
REQ-001 Parameter SYNC_STAGES, 2, synchronizer depth (>=2) on S_CLK, CS and MOSI.
REQ-002 Parameter DUMMY_BYTE, 8'hFF, byte shifted out when no transmit data is loaded.
REQ-003 CLK  input  1  system clock; all state changes on rising edge.
REQ-004 CLR  input  1  synchronous, active-high reset.
REQ-005 WRITE  input  1  one-cycle strobe; loads INCOMING_DATA into the TX holding register.
REQ-006 READ  input  1  one-cycle strobe; acknowledges the RX data register.
REQ-007 INCOMING_DATA  input  8  byte to transmit on MISO.
REQ-008 OUTCOMING_DATA  output  8  last complete received byte, continuously driven from the RX data register.
REQ-009 STATUS  output  8  [0] RX_FULL, [1] TX_FULL, [2] OVERRUN, [3] BUSY, [7:4] 0.
REQ-010 S_CLK  input  1  SPI clock from master, asynchronous to CLK.
REQ-011 CS  input  1  chip select from master, active low, asynchronous.
REQ-012 MOSI  input  1  serial data from master, asynchronous.
REQ-013 MISO  output  1  serial data to master.
REQ-014 MISO_OE  output  1  MISO drive enable; high only while BUSY.

Function
REQ-015 SPI mode 0 only: MOSI sampled on S_CLK rising edge, MISO changes on S_CLK falling edge, MSB first, 8-bit frames.
REQ-016 S_CLK, CS, MOSI pass through SYNC_STAGES flops; edges are detected by comparing the synchronized value with its one-cycle-delayed copy.
REQ-017 CLK frequency shall be >= 8x S_CLK; slower CLK is out of scope.
REQ-018 States: IDLE (CS_s high), SHIFT (CS_s low); BUSY = (state==SHIFT).
REQ-019 IDLE->SHIFT on detected CS fall: bit_cnt=0; tx_shift = TX_FULL ? tx_hold : DUMMY_BYTE; TX_FULL cleared; MISO = new tx_shift[7] in that same cycle.
REQ-020 WRITE coincident with the load while TX_FULL=0: INCOMING_DATA is loaded directly into tx_shift, and TX_FULL stays 0.
REQ-021 S_CLK rise in SHIFT: rx_shift = {rx_shift[6:0], MOSI_s}; bit_cnt increments modulo 8.
REQ-022 Rise with bit_cnt==7: RX data register = completed byte and RX_FULL=1, both visible the cycle after edge detection.
REQ-023 S_CLK fall in SHIFT with bit_cnt!=0: tx_shift shifts left one bit; MISO = tx_shift[7].
REQ-024 S_CLK fall with bit_cnt==0 after at least one completed byte: reload tx_shift as in REQ-019 for back-to-back frames.
REQ-025 SHIFT->IDLE on detected CS rise at any bit_cnt: partial rx_shift discarded, no RX_FULL, bit_cnt=0, MISO_OE=0.
REQ-026 WRITE while TX_FULL=1 overwrites tx_hold; TX_FULL remains 1.
REQ-027 READ clears RX_FULL on the next edge; if READ coincides with byte completion, the new byte is stored and RX_FULL stays 1.
REQ-028 S_CLK edges while CS_s is high are ignored.
REQ-029 MISO = 0 when MISO_OE = 0.

Reset
REQ-030 CLR high at a rising CLK edge forces: state IDLE, bit_cnt 0, tx_shift, rx_shift, tx_hold and RX data register 8'h00, STATUS 8'h00, MISO 0, MISO_OE 0.
REQ-031 Synchronizer flops reset to the idle bus levels: CS 1, S_CLK 0, MOSI 0.
REQ-032 CLR during SHIFT aborts the frame; the core re-arms only on a fresh CS fall after CLR is released.

Configuration
REQ-033 Macro SPI_SLAVE_OVERRUN_EN defined: byte completion while RX_FULL=1 and no coincident READ sets sticky OVERRUN; the new byte overwrites the RX data register; READ or CLR clears OVERRUN.
REQ-034 Macro undefined: STATUS[2] is constant 0, and no overrun logic is synthesized; overwrite behaviour is unchanged.

Verification
REQ-035 WRITE 8'hA5, then CS low and master sends 8'h3C -> MISO bits 1,0,1,0,0,1,0,1; OUTCOMING_DATA=8'h3C; RX_FULL=1; TX_FULL=0.
REQ-036 No WRITE, then a frame -> MISO carries 8'hFF; TX_FULL stays 0.
REQ-037 CS rises after 5 bits of 8'hF0 -> RX_FULL=0, RX data register unchanged, BUSY=0, next frame 8'h81 is received correctly.
REQ-038 Two back-to-back frames 8'h11, 8'h22 with tx_hold rewritten between them (8'h55, 8'hAA) -> MISO 8'h55 then 8'hAA; both bytes are received, and OVERRUN=1 (with SPI_SLAVE_OVERRUN_EN) if there is no READ in between.
REQ-039 READ on the exact cycle byte 8'h77 completes -> OUTCOMING_DATA=8'h77, RX_FULL=1, OVERRUN=0.
REQ-040 CLR asserted mid-frame at bit 3 -> every output matches REQ-030 on the next cycle.

Source files
------------

// File: rtl/spi_slave_core.sv
// SPI mode-0 slave core: 8-bit MSB-first frames, synchronized S_CLK/CS/MOSI, TX holding and RX data registers.
// Optional sticky overrun flag is built only when SPI_SLAVE_OVERRUN_EN is defined.
module spi_slave_core #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  DUMMY_BYTE  = 8'hFF
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       WRITE,
  input  logic       READ,
  input  logic [7:0] INCOMING_DATA,
  output logic [7:0] OUTCOMING_DATA,
  output logic [7:0] STATUS,
  input  logic       S_CLK,
  input  logic       CS,
  input  logic       MOSI,
  output logic       MISO,
  output logic       MISO_OE
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic [SYNC_STAGES:0]   settle;
  logic [2:0]             bit_cnt;
  logic [7:0]             tx_shift, rx_shift, tx_hold, rx_data;
  logic                   tx_full, rx_full, overrun, byte_seen, miso_q;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic load_evt, byte_done;
  logic [7:0] load_dat, rx_next;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  // The reset value of the CS chain is not a real observation; a fall only
  // counts once the chain and its delayed copy hold genuine samples.
  assign cs_fall   = ~cs_s & cs_d & settle[SYNC_STAGES];
  assign cs_rise   = cs_s & ~cs_d;

  assign load_evt  = ((state == IDLE) && cs_fall) ||
                     ((state == SHIFT) && !cs_rise && sclk_fall && (bit_cnt == 3'd0) && byte_seen);
  assign load_dat  = tx_full ? tx_hold : (WRITE ? INCOMING_DATA : DUMMY_BYTE);
  assign byte_done = (state == SHIFT) && !cs_rise && sclk_rise && (bit_cnt == 3'd7);
  assign rx_next   = {rx_shift[6:0], mosi_s};

  always_ff @(posedge CLK) begin
    if (CLR) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      settle    <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], S_CLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      settle    <= {settle[SYNC_STAGES-1:0], 1'b1};
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      tx_shift  <= 8'h00;
      rx_shift  <= 8'h00;
      byte_seen <= 1'b0;
      miso_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state     <= SHIFT;
            bit_cnt   <= 3'd0;
            byte_seen <= 1'b0;
            tx_shift  <= load_dat;
            miso_q    <= load_dat[7];
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            miso_q  <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              byte_seen <= 1'b1;
          end else if (sclk_fall) begin
            if (bit_cnt != 3'd0) begin
              tx_shift <= {tx_shift[6:0], 1'b0};
              miso_q   <= tx_shift[6];
            end else if (byte_seen) begin
              tx_shift <= load_dat;
              miso_q   <= load_dat[7];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A WRITE landing on a load while the holding register is empty goes
  // straight into the shifter and never marks the holding register full.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      tx_hold <= 8'h00;
      tx_full <= 1'b0;
    end else if (WRITE && !(load_evt && !tx_full)) begin
      tx_hold <= INCOMING_DATA;
      tx_full <= 1'b1;
    end else if (load_evt) begin
      tx_full <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      rx_data <= 8'h00;
      rx_full <= 1'b0;
    end else if (byte_done) begin
      rx_data <= rx_next;
      rx_full <= 1'b1;
    end else if (READ) begin
      rx_full <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  always_ff @(posedge CLK) begin
    if (CLR)
      overrun <= 1'b0;
    else if (READ)
      overrun <= 1'b0;
    else if (byte_done && rx_full)
      overrun <= 1'b1;
  end
`else
  assign overrun = 1'b0;
`endif

  assign OUTCOMING_DATA = rx_data;
  assign STATUS         = {4'b0000, (state == SHIFT), overrun, tx_full, rx_full};
  assign MISO_OE        = (state == SHIFT);
  assign MISO           = miso_q & MISO_OE;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: directed mode-0 frames plus randomized frames against a byte-level model.
module tb_spi_slave_core;

  localparam int         SYNC  = 2;
  localparam int         HALF  = 6;
  localparam logic [7:0] DUMMY = 8'hFF;
`ifdef SPI_SLAVE_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic       clk, clr, write, read;
  logic [7:0] incoming, outcoming, status;
  logic       s_clk, cs, mosi, miso, miso_oe;

  int n_asserts = 0;
  int n_fail    = 0;

  // byte-level reference model state
  logic [7:0] m_rx, m_hold, m_tx;
  logic       m_rxf, m_ovr, m_full;

  spi_slave_core #(.SYNC_STAGES(SYNC), .DUMMY_BYTE(DUMMY)) dut (
    .CLK(clk), .CLR(clr), .WRITE(write), .READ(read),
    .INCOMING_DATA(incoming), .OUTCOMING_DATA(outcoming), .STATUS(status),
    .S_CLK(s_clk), .CS(cs), .MOSI(mosi), .MISO(miso), .MISO_OE(miso_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_status(input logic busy);
    return {4'b0000, busy, m_ovr, m_full, m_rxf};
  endfunction

  task automatic model_reset();
    m_rx = 8'h00; m_hold = 8'h00; m_tx = 8'h00;
    m_rxf = 1'b0; m_ovr = 1'b0; m_full = 1'b0;
  endtask

  task automatic consume();
    m_tx   = m_full ? m_hold : DUMMY;
    m_full = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] d);
    incoming = d; write = 1'b1;
    tick(1);
    write = 1'b0;
    m_hold = d; m_full = 1'b1;
  endtask

  task automatic do_read();
    read = 1'b1;
    tick(1);
    read = 1'b0;
    m_rxf = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic cs_low(input bit wr_at_load, input logic [7:0] d);
    cs = 1'b0;
    if (wr_at_load) begin
      tick(SYNC);
      incoming = d; write = 1'b1;
      tick(1);
      write = 1'b0;
      tick(HALF - SYNC - 1);
      if (m_full) begin
        m_tx = m_hold; m_hold = d;
      end else begin
        m_tx = d;
      end
    end else begin
      tick(HALF);
      consume();
    end
    check("start_status", status, exp_status(1'b1));
    check("start_miso", miso, m_tx[7]);
  endtask

  task automatic cs_high();
    cs = 1'b1;
    tick(HALF);
    check("end_status", status, exp_status(1'b0));
    check("end_miso", miso, 1'b0);
    check("end_miso_oe", miso_oe, 1'b0);
    check("end_rxdata", outcoming, m_rx);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits, input bit rd_last,
                          input bit wr_mid, input logic [7:0] wd);
    logic [7:0] got, mask;
    got = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      mosi = b[7-k];
      tick(HALF);
      got[7-k] = miso;
      s_clk = 1'b1;
      if (rd_last && k == 7) begin
        tick(SYNC);
        read = 1'b1;
        tick(1);
        read = 1'b0;
        tick(HALF - SYNC - 1);
      end else if (wr_mid && k == 3) begin
        tick(2);
        incoming = wd; write = 1'b1;
        tick(1);
        write = 1'b0;
        tick(HALF - 3);
        m_hold = wd; m_full = 1'b1;
      end else begin
        tick(HALF);
      end
      s_clk = 1'b0;
    end
    tick(HALF);
    mask = 8'hFF << (8 - nbits);
    check("miso_bits", got & mask, m_tx & mask);
    if (nbits == 8) begin
      if (rd_last)
        m_ovr = 1'b0;
      else if (m_rxf && OVR_EN)
        m_ovr = 1'b1;
      m_rx  = b;
      m_rxf = 1'b1;
      consume();
      check("byte_rxdata", outcoming, m_rx);
      check("byte_status", status, exp_status(1'b1));
      check("byte_miso_oe", miso_oe, 1'b1);
    end
  endtask

  initial begin
    int nb, nbits;
    clr = 1'b1; write = 1'b0; read = 1'b0; incoming = 8'h00;
    s_clk = 1'b0; cs = 1'b1; mosi = 1'b0;
    model_reset();
    tick(3);
    clr = 1'b0;
    tick(SYNC + 3);
    check("rst_rxdata", outcoming, 8'h00);
    check("rst_status", status, 8'h00);
    check("rst_miso", miso, 1'b0);
    check("rst_miso_oe", miso_oe, 1'b0);

    // loaded byte goes out while 3C comes in
    do_write(8'hA5);
    check("wr_txfull", status, exp_status(1'b0));
    cs_low(1'b0, 8'h00);
    spi_bits(8'h3C, 8, 1'b0, 1'b0, 8'h00);
    cs_high();

    // nothing loaded: dummy byte
    cs_low(1'b0, 8'h00);
    spi_bits(8'h5E, 8, 1'b0, 1'b0, 8'h00);
    cs_high();

    // second write overwrites the holding register
    do_write(8'h12);
    do_write(8'h34);
    cs_low(1'b0, 8'h00);
    spi_bits(8'hC7, 8, 1'b0, 1'b0, 8'h00);
    cs_high();

    // aborted partial frame, then a clean one
    do_read();
    cs_low(1'b0, 8'h00);
    spi_bits(8'hF0, 5, 1'b0, 1'b0, 8'h00);
    cs_high();
    cs_low(1'b0, 8'h00);
    spi_bits(8'h81, 8, 1'b0, 1'b0, 8'h00);
    cs_high();

    // back-to-back bytes, holding register refilled mid-byte
    do_read();
    do_write(8'h55);
    cs_low(1'b0, 8'h00);
    spi_bits(8'h11, 8, 1'b0, 1'b1, 8'hAA);
    spi_bits(8'h22, 8, 1'b0, 1'b0, 8'h00);
    cs_high();

    // WRITE on the load cycle with an empty holding register
    cs_low(1'b1, 8'h6B);
    spi_bits(8'h0F, 8, 1'b0, 1'b0, 8'h00);
    cs_high();

    // READ coincident with byte completion
    cs_low(1'b0, 8'h00);
    spi_bits(8'h44, 8, 1'b0, 1'b0, 8'h00);
    spi_bits(8'h77, 8, 1'b1, 1'b0, 8'h00);
    cs_high();

    // CLR mid-frame, CS still held low afterwards
    do_write(8'h39);
    cs_low(1'b0, 8'h00);
    spi_bits(8'hC3, 3, 1'b0, 1'b0, 8'h00);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    model_reset();
    check("clr_rxdata", outcoming, 8'h00);
    check("clr_status", status, 8'h00);
    check("clr_miso", miso, 1'b0);
    check("clr_miso_oe", miso_oe, 1'b0);
    tick(20);
    check("clr_no_rearm", status, 8'h00);
    cs_high();
    do_write(8'h5A);
    cs_low(1'b0, 8'h00);
    spi_bits(8'h96, 8, 1'b0, 1'b0, 8'h00);
    cs_high();

    // randomized frames
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(1, 0) == 1) do_write(8'($urandom));
      if ($urandom_range(2, 0) == 0) do_read();
      cs_low(1'b0, 8'h00);
      nb = $urandom_range(3, 1);
      for (int j = 0; j < nb; j++) begin
        nbits = 8;
        if (j == nb - 1 && $urandom_range(3, 0) == 0) nbits = $urandom_range(7, 1);
        spi_bits(8'($urandom), nbits,
                 (nbits == 8) && ($urandom_range(3, 0) == 0),
                 $urandom_range(2, 0) == 0, 8'($urandom));
      end
      cs_high();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
